alu_result_stage: RTL

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage
// Purpose  : 2-entry in-order result buffer between ALU and write-back that
//            also maintains the architectural carry/zero flags.
//            Optional macro ALU_RESULT_STATS_EN adds a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_opcode,
  input  logic [7:0]  in_result,
  input  logic        in_cout,
  input  logic [2:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_result,
  output logic [2:0]  out_rd,
  output logic        carry_flag,
  output logic        zero_flag,
  output logic        cin,
  input  logic        flags_clr
`ifdef ALU_RESULT_STATS_EN
  ,
  output logic [15:0] stall_count
`endif
);

  // Function codes shared with the ALU; only the carry-producing ones matter here.
  localparam logic [2:0] ADD_FN  = 3'd0;
  localparam logic [2:0] ADDC_FN = 3'd1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        push;
  logic        head_load_in;
  logic        head_load_tail;
  logic        tail_load_in;
  logic [7:0]  head_result;
  logic [2:0]  head_rd;
  logic [7:0]  tail_result;
  logic [2:0]  tail_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake and entry movement depend only on the state and the request lines.
  always_comb begin
    state_nxt      = state;
    in_ready       = 1'b1;
    out_valid      = 1'b0;
    head_load_in   = 1'b0;
    head_load_tail = 1'b0;
    tail_load_in   = 1'b0;
    case (state)
      EMPTY: begin
        if (in_valid) begin
          state_nxt    = ONE;
          head_load_in = 1'b1;
        end
      end
      ONE: begin
        out_valid = 1'b1;
        if (in_valid && out_ready) begin
          head_load_in = 1'b1;
        end else if (in_valid) begin
          state_nxt    = FULL;
          tail_load_in = 1'b1;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt      = ONE;
          head_load_tail = 1'b1;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  assign push = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_result <= 8'h00;
      head_rd     <= 3'd0;
      tail_result <= 8'h00;
      tail_rd     <= 3'd0;
    end else begin
      if (head_load_in) begin
        head_result <= in_result;
        head_rd     <= in_rd;
      end else if (head_load_tail) begin
        head_result <= tail_result;
        head_rd     <= tail_rd;
      end
      if (tail_load_in) begin
        tail_result <= in_result;
        tail_rd     <= in_rd;
      end
    end
  end

  assign out_result = out_valid ? head_result : 8'h00;
  assign out_rd     = out_valid ? head_rd     : 3'd0;

  // Flags track acceptance order, not write-back order; clear beats a push update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else if (flags_clr) begin
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else if (push) begin
      zero_flag <= (in_result == 8'h00);
      if ((in_opcode == ADD_FN) || (in_opcode == ADDC_FN)) begin
        carry_flag <= in_cout;
      end
    end
  end

  assign cin = carry_flag;

`ifdef ALU_RESULT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= 16'h0000;
    end else if (in_valid && !in_ready && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'h0001;
    end
  end
`endif

endmodule
`default_nettype wire
